lsu_ctrl: RTL and testbench

Load/store controller between the CPU execute stage and the MEMORY block. Accepts one load or store request at a time over a valid/ready handshake and drives MEMORY's single word-wide port (memread/memwrite/memaddr/memwdata, one-cycle registered read data). Performs byte/halfword extraction with sign/zero extension on loads and read-modify-write merging for sub-word stores. Returns one response per request, with an error flag for misaligned or illegal accesses.

---
 rtl/lsu_ctrl_if.sv | 36 +++
 rtl/lsu_ctrl.sv | 169 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// Request/response handshake and MEMORY port bundle for lsu_ctrl.
// slave = controller view, master = CPU execute stage plus MEMORY view.
interface lsu_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [1:0]        req_size_i;
    logic              req_unsigned_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [DATA_W-1:0] req_wdata_i;
    logic              resp_valid_o;
    logic [DATA_W-1:0] resp_rdata_o;
    logic              resp_err_o;
    logic              memread_o;
    logic              memwrite_o;
    logic [ADDR_W-1:0] memaddr_o;
    logic [DATA_W-1:0] memwdata_o;
    logic [DATA_W-1:0] memrdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i,
               req_addr_i, req_wdata_i, memrdata_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
               memread_o, memwrite_o, memaddr_o, memwdata_o
    );

    modport master (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i,
               req_addr_i, req_wdata_i, memrdata_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
               memread_o, memwrite_o, memaddr_o, memwdata_o
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store controller: one request at a time, sub-word load extension and
// read-modify-write sub-word stores (built only when LSU_RMW_EN is defined).
module lsu_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    lsu_ctrl_if.slave  bus
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LD_REQ   = 3'd1;
    localparam logic [2:0] LD_DATA  = 3'd2;
    localparam logic [2:0] ST_WR    = 3'd5;
    localparam logic [2:0] RESP     = 3'd6;
`ifdef LSU_RMW_EN
    localparam logic [2:0] RMW_REQ  = 3'd3;
    localparam logic [2:0] RMW_DATA = 3'd4;
`endif

    logic [2:0]        r_state;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [1:0]        r_offset;
    logic [ADDR_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memWdata;
    logic [DATA_W-1:0] r_respData;
    logic              r_respErr;
`ifdef LSU_RMW_EN
    logic [15:0]       r_wdata;
`endif

    logic w_accept;
    logic w_reqErr;

    assign w_accept = (r_state == IDLE) && bus.req_valid_i;

    // Without the RMW path, any store narrower than a word is also illegal.
    always_comb begin
        w_reqErr = (bus.req_size_i == 2'b11)
                || (bus.req_size_i == 2'b01 && bus.req_addr_i[0])
                || (bus.req_size_i == 2'b10 && bus.req_addr_i[1:0] != 2'b00);
`ifndef LSU_RMW_EN
        if (bus.req_we_i && bus.req_size_i != 2'b10)
            w_reqErr = 1'b1;
`endif
    end

    function automatic logic [DATA_W-1:0] extractLoad(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        size,
        input logic [1:0]        off,
        input logic              uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (size)
            2'b00:   extractLoad = {{(DATA_W-8){b[7] & ~uns}}, b};
            2'b01:   extractLoad = {{(DATA_W-16){h[15] & ~uns}}, h};
            default: extractLoad = word;
        endcase
    endfunction

`ifdef LSU_RMW_EN
    function automatic logic [DATA_W-1:0] mergeStore(
        input logic [DATA_W-1:0] word,
        input logic [15:0]       wdata,
        input logic [1:0]        size,
        input logic [1:0]        off
    );
        mergeStore = word;
        if (size == 2'b00)
            mergeStore[{off, 3'b000} +: 8] = wdata[7:0];
        else
            mergeStore[{off[1], 4'b0000} +: 16] = wdata;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_offset   <= 2'b00;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_respData <= '0;
            r_respErr  <= 1'b0;
`ifdef LSU_RMW_EN
            r_wdata    <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_size     <= bus.req_size_i;
                        r_unsigned <= bus.req_unsigned_i;
                        r_offset   <= bus.req_addr_i[1:0];
`ifdef LSU_RMW_EN
                        r_wdata    <= bus.req_wdata_i[15:0];
`endif
                        // Errored requests never touch memaddr so it keeps its last value.
                        if (w_reqErr) begin
                            r_respErr  <= 1'b1;
                            r_respData <= '0;
                            r_state    <= RESP;
                        end else begin
                            r_memAddr <= {bus.req_addr_i[ADDR_W-1:2], 2'b00};
                            if (!bus.req_we_i) begin
                                r_state <= LD_REQ;
                            end else if (bus.req_size_i == 2'b10) begin
                                r_memWdata <= bus.req_wdata_i;
                                r_state    <= ST_WR;
                            end else begin
`ifdef LSU_RMW_EN
                                r_state <= RMW_REQ;
`else
                                r_state <= RESP;
`endif
                            end
                        end
                    end
                end
                LD_REQ: r_state <= LD_DATA;
                LD_DATA: begin
                    r_respData <= extractLoad(bus.memrdata_i, r_size, r_offset, r_unsigned);
                    r_respErr  <= 1'b0;
                    r_state    <= RESP;
                end
`ifdef LSU_RMW_EN
                RMW_REQ: r_state <= RMW_DATA;
                RMW_DATA: begin
                    r_memWdata <= mergeStore(bus.memrdata_i, r_wdata, r_size, r_offset);
                    r_state    <= ST_WR;
                end
`endif
                ST_WR: begin
                    r_memWdata <= '0;
                    r_respData <= '0;
                    r_respErr  <= 1'b0;
                    r_state    <= RESP;
                end
                RESP: begin
                    r_respData <= '0;
                    r_respErr  <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready_o  = (r_state == IDLE);
    assign bus.resp_valid_o = (r_state == RESP);
    assign bus.resp_rdata_o = r_respData;
    assign bus.resp_err_o   = r_respErr;
`ifdef LSU_RMW_EN
    assign bus.memread_o    = (r_state == LD_REQ) || (r_state == RMW_REQ);
`else
    assign bus.memread_o    = (r_state == LD_REQ);
`endif
    assign bus.memwrite_o   = (r_state == ST_WR);
    assign bus.memaddr_o    = r_memAddr;
    assign bus.memwdata_o   = r_memWdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: driver queues expected responses and memory
// strobes, a negedge monitor pops and compares them as the DUT presents them.
module tb_lsu_ctrl;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          cyc;
    } respExp_t;

    typedef struct {
        logic        isWrite;
        logic [15:0] addr;
        logic [31:0] data;
        int          cyc;
    } memExp_t;

    logic clk;
    logic rst;
    logic memInit;
    int   cycleCnt = 0;
    int   checks   = 0;
    int   errors   = 0;

    respExp_t respQ[$];
    memExp_t  memQ[$];
    logic [31:0] mem [0:16383];

    lsu_ctrl_if #(.DATA_W(32), .ADDR_W(16)) bus ();

    lsu_ctrl #(.DATA_W(32), .ADDR_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // MEMORY model: registered read data, write on the same edge as memwrite.
    always @(posedge clk) begin
        if (memInit) begin
            for (int i = 0; i < 16384; i++) mem[i] <= 32'h0;
            mem[16'h1008 >> 2] <= 32'h80FF7F01;
            mem[16'h1010 >> 2] <= 32'h11223344;
            bus.memrdata_i <= 32'h0;
        end else begin
            if (bus.memwrite_o) mem[bus.memaddr_o[15:2]] <= bus.memwdata_o;
            if (bus.memread_o)  bus.memrdata_i <= mem[bus.memaddr_o[15:2]];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycleCnt);
        end
    endtask

    // Monitor: every response and every memory strobe must match the next queued expectation.
    always @(negedge clk) begin
        respExp_t r;
        memExp_t  m;
        if (bus.resp_valid_o) begin
            if (respQ.size() == 0) begin
                checkOutput("unexpectedResp", 32'd1, 32'd0);
            end else begin
                r = respQ.pop_front();
                checkOutput("respErr", {31'd0, bus.resp_err_o}, {31'd0, r.err});
                checkOutput("respData", bus.resp_rdata_o, r.data);
                checkOutput("respCycle", cycleCnt, r.cyc);
            end
        end
        if (bus.memread_o || bus.memwrite_o) begin
            checkOutput("strobeExclusive", {31'd0, bus.memread_o & bus.memwrite_o}, 32'd0);
            if (memQ.size() == 0) begin
                checkOutput("unexpectedMemAccess", 32'd1, 32'd0);
            end else begin
                m = memQ.pop_front();
                checkOutput("memIsWrite", {31'd0, bus.memwrite_o}, {31'd0, m.isWrite});
                checkOutput("memAddr", {16'd0, bus.memaddr_o}, {16'd0, m.addr});
                checkOutput("memCycle", cycleCnt, m.cyc);
                if (m.isWrite) checkOutput("memWdata", bus.memwdata_o, m.data);
            end
        end
    end

    task automatic waitReady(output logic ok);
        int waitCnt;
        waitCnt = 0;
        @(negedge clk);
        while (bus.req_ready_o !== 1'b1 && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        ok = (waitCnt < 50);
        if (!ok) checkOutput("readyTimeout", 32'd0, 32'd1);
    endtask

    // expData is the load result, or the merged memory word for sub-word stores.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [15:0] addr, input logic [31:0] wdata,
                                 input logic expErr, input logic [31:0] expData);
        logic        ok;
        int          t;
        logic [15:0] wordAddr;
        waitReady(ok);
        if (!ok) return;
        t = cycleCnt;
        wordAddr = {addr[15:2], 2'b00};
        bus.req_we_i       = we;
        bus.req_size_i     = size;
        bus.req_unsigned_i = uns;
        bus.req_addr_i     = addr;
        bus.req_wdata_i    = wdata;
        bus.req_valid_i    = 1'b1;
        if (expErr) begin
            respQ.push_back('{1'b1, 32'h0, t + 1});
        end else if (!we) begin
            memQ.push_back('{1'b0, wordAddr, 32'h0, t + 1});
            respQ.push_back('{1'b0, expData, t + 3});
        end else if (size == 2'b10) begin
            memQ.push_back('{1'b1, wordAddr, wdata, t + 1});
            respQ.push_back('{1'b0, 32'h0, t + 2});
        end else begin
            memQ.push_back('{1'b0, wordAddr, 32'h0, t + 1});
            memQ.push_back('{1'b1, wordAddr, expData, t + 3});
            respQ.push_back('{1'b0, 32'h0, t + 4});
        end
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        bus.req_wdata_i = 32'h0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic ok;
        bus.req_valid_i    = 1'b0;
        bus.req_we_i       = 1'b0;
        bus.req_size_i     = 2'b00;
        bus.req_unsigned_i = 1'b0;
        bus.req_addr_i     = 16'h0;
        bus.req_wdata_i    = 32'h0;
        rst     = 1'b1;
        memInit = 1'b1;
        repeat (3) @(negedge clk);
        rst     = 1'b0;
        memInit = 1'b0;

        checkOutput("rstReady",     {31'd0, bus.req_ready_o},  32'd1);
        checkOutput("rstRespValid", {31'd0, bus.resp_valid_o}, 32'd0);
        checkOutput("rstRespErr",   {31'd0, bus.resp_err_o},   32'd0);
        checkOutput("rstRespData",  bus.resp_rdata_o,          32'd0);
        checkOutput("rstMemRead",   {31'd0, bus.memread_o},    32'd0);
        checkOutput("rstMemWrite",  {31'd0, bus.memwrite_o},   32'd0);
        checkOutput("rstMemAddr",   {16'd0, bus.memaddr_o},    32'd0);
        checkOutput("rstMemWdata",  bus.memwdata_o,            32'd0);

        applyStimulus(1'b1, 2'b10, 1'b0, 16'h1004, 32'hDEADBEEF, 1'b0, 32'h0);
        applyStimulus(1'b0, 2'b10, 1'b0, 16'h1004, 32'h0, 1'b0, 32'hDEADBEEF);
        applyStimulus(1'b0, 2'b00, 1'b0, 16'h1009, 32'h0, 1'b0, 32'h0000007F);
        applyStimulus(1'b0, 2'b00, 1'b0, 16'h100A, 32'h0, 1'b0, 32'hFFFFFFFF);
        applyStimulus(1'b0, 2'b00, 1'b1, 16'h100B, 32'h0, 1'b0, 32'h00000080);
        applyStimulus(1'b0, 2'b00, 1'b0, 16'h100B, 32'h0, 1'b0, 32'hFFFFFF80);
        applyStimulus(1'b0, 2'b01, 1'b0, 16'h100A, 32'h0, 1'b0, 32'hFFFF80FF);
        applyStimulus(1'b0, 2'b01, 1'b1, 16'h1008, 32'h0, 1'b0, 32'h00007F01);

        applyStimulus(1'b0, 2'b10, 1'b0, 16'h1002, 32'h0, 1'b1, 32'h0);
        applyStimulus(1'b1, 2'b01, 1'b0, 16'h1001, 32'h0000BEEF, 1'b1, 32'h0);
        applyStimulus(1'b0, 2'b11, 1'b0, 16'h1000, 32'h0, 1'b1, 32'h0);
        applyStimulus(1'b0, 2'b01, 1'b0, 16'h1003, 32'h0, 1'b1, 32'h0);

`ifdef LSU_RMW_EN
        applyStimulus(1'b1, 2'b00, 1'b0, 16'h1011, 32'h000000AA, 1'b0, 32'h1122AA44);
        applyStimulus(1'b1, 2'b01, 1'b0, 16'h1012, 32'h0000BEEF, 1'b0, 32'hBEEFAA44);
        applyStimulus(1'b0, 2'b10, 1'b0, 16'h1010, 32'h0, 1'b0, 32'hBEEFAA44);
        applyStimulus(1'b0, 2'b00, 1'b0, 16'h1011, 32'h0, 1'b0, 32'hFFFFFFAA);
`else
        applyStimulus(1'b1, 2'b00, 1'b0, 16'h1011, 32'h000000AA, 1'b1, 32'h0);
        applyStimulus(1'b0, 2'b10, 1'b0, 16'h1010, 32'h0, 1'b0, 32'h11223344);
`endif

        applyStimulus(1'b1, 2'b10, 1'b0, 16'hFFFC, 32'h12345678, 1'b0, 32'h0);
        applyStimulus(1'b0, 2'b10, 1'b0, 16'hFFFC, 32'h0, 1'b0, 32'h12345678);

        // Back-to-back loads with valid held high: one accept every 4 cycles.
        waitReady(ok);
        if (ok) begin
            bus.req_we_i       = 1'b0;
            bus.req_size_i     = 2'b10;
            bus.req_unsigned_i = 1'b0;
            bus.req_addr_i     = 16'h1008;
            bus.req_valid_i    = 1'b1;
            for (int k = 0; k < 12; k++) begin
                if (k > 0) @(negedge clk);
                checkOutput("b2bReady", {31'd0, bus.req_ready_o}, {31'd0, (k % 4) == 0});
                if ((k % 4) == 0) begin
                    memQ.push_back('{1'b0, 16'h1008, 32'h0, cycleCnt + 1});
                    respQ.push_back('{1'b0, 32'h80FF7F01, cycleCnt + 3});
                end
            end
            bus.req_valid_i = 1'b0;
        end

        // Reset mid-transaction: only the read strobe may appear, no response, no write.
        waitReady(ok);
        if (ok) begin
`ifdef LSU_RMW_EN
            bus.req_we_i    = 1'b1;
            bus.req_size_i  = 2'b00;
            bus.req_addr_i  = 16'h1013;
            bus.req_wdata_i = 32'h00000055;
            memQ.push_back('{1'b0, 16'h1010, 32'h0, cycleCnt + 1});
`else
            bus.req_we_i    = 1'b0;
            bus.req_size_i  = 2'b10;
            bus.req_addr_i  = 16'h1004;
            memQ.push_back('{1'b0, 16'h1004, 32'h0, cycleCnt + 1});
`endif
            bus.req_unsigned_i = 1'b0;
            bus.req_valid_i    = 1'b1;
            @(negedge clk);
            bus.req_valid_i = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            checkOutput("postRstReady",     {31'd0, bus.req_ready_o},  32'd1);
            checkOutput("postRstRespValid", {31'd0, bus.resp_valid_o}, 32'd0);
            checkOutput("postRstMemWrite",  {31'd0, bus.memwrite_o},   32'd0);
            checkOutput("postRstMemWdata",  bus.memwdata_o,            32'd0);
        end

`ifdef LSU_RMW_EN
        applyStimulus(1'b0, 2'b10, 1'b0, 16'h1010, 32'h0, 1'b0, 32'hBEEFAA44);
`else
        applyStimulus(1'b0, 2'b10, 1'b0, 16'h1004, 32'h0, 1'b0, 32'hDEADBEEF);
`endif

        repeat (10) @(negedge clk);
        checkOutput("respQueueDrained", respQ.size(), 32'd0);
        checkOutput("memQueueDrained",  memQ.size(),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
